// File: rtl/irq_controller_n.sv
// Prioritised interrupt controller: fixed priority (index 0 highest), registered IRQ/vector handshake.
// Define IRQ_NESTING_EN to allow a higher-priority source to preempt one already in service.
module irq_controller_n #(
    parameter int NUM_SRC       = 3,
    parameter int I_ADDR_WIDTH  = 10,
    parameter int VECTOR_BASE   = 1,
    parameter int VECTOR_STRIDE = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    gie,
    input  logic [NUM_SRC-1:0]      src_flag,
    input  logic [NUM_SRC-1:0]      src_mask,
    input  logic                    irq_ack,
    input  logic                    reti,
    output logic                    irq,
    output logic [I_ADDR_WIDTH-1:0] vector,
    output logic [NUM_SRC-1:0]      flag_clr,
    output logic [NUM_SRC-1:0]      in_service,
    output logic                    proto_err
);

    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    logic [1:0]              state, state_nx;
    logic [IDX_W-1:0]        req_idx, req_idx_nx;
    logic                    irq_nx;
    logic [I_ADDR_WIDTH-1:0] vector_nx;
    logic [NUM_SRC-1:0]      flag_clr_nx;
    logic [NUM_SRC-1:0]      in_service_nx;
    logic                    proto_err_nx;

    logic [NUM_SRC-1:0]      isv_low;
    logic [NUM_SRC-1:0]      allowed;
    logic [NUM_SRC-1:0]      eligible;
    logic                    any_elig;
    logic                    found;
    logic [IDX_W-1:0]        win_idx;
    logic [I_ADDR_WIDTH-1:0] win_vec;
    logic [NUM_SRC-1:0]      acked_onehot;

    // Only sources strictly above the highest-priority in-service source may request.
    always_comb begin
        isv_low  = in_service & ((~in_service) + NUM_SRC'(1));
        allowed  = (isv_low == '0) ? '1 : (isv_low - NUM_SRC'(1));
        eligible = {NUM_SRC{gie}} & src_flag & src_mask & allowed;
        any_elig = |eligible;
    end

    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (eligible[i] && !found) begin
                win_idx = IDX_W'(i);
                found   = 1'b1;
            end
        end
    end

    assign win_vec      = I_ADDR_WIDTH'(VECTOR_BASE)
                        + I_ADDR_WIDTH'(win_idx) * I_ADDR_WIDTH'(VECTOR_STRIDE);
    assign acked_onehot = NUM_SRC'(1) << req_idx;

    always_comb begin
        state_nx      = state;
        irq_nx        = irq;
        vector_nx     = vector;
        req_idx_nx    = req_idx;
        flag_clr_nx   = '0;
        in_service_nx = in_service;
        proto_err_nx  = 1'b0;

        // A reti coinciding with an ack is discarded; the ack always wins.
        if (reti) begin
            if (irq_ack || (in_service == '0)) begin
                proto_err_nx = 1'b1;
            end else begin
                in_service_nx = in_service & ~isv_low;
            end
        end

        if (irq_ack && (state != ST_REQ)) begin
            proto_err_nx = 1'b1;
        end

        case (state)
            ST_IDLE: begin
                if (any_elig) begin
                    state_nx   = ST_REQ;
                    irq_nx     = 1'b1;
                    vector_nx  = win_vec;
                    req_idx_nx = win_idx;
                end
            end

            ST_REQ: begin
                if (irq_ack) begin
                    flag_clr_nx   = acked_onehot;
                    in_service_nx = in_service | acked_onehot;
                    irq_nx        = 1'b0;
                    state_nx      = ST_SERVICE;
                end else if (any_elig) begin
                    vector_nx  = win_vec;
                    req_idx_nx = win_idx;
                end else begin
                    irq_nx   = 1'b0;
                    state_nx = (in_service_nx != '0) ? ST_SERVICE : ST_IDLE;
                end
            end

            ST_SERVICE: begin
                if (in_service_nx == '0) begin
                    state_nx = ST_IDLE;
                end
`ifdef IRQ_NESTING_EN
                else if (!reti && any_elig) begin
                    state_nx   = ST_REQ;
                    irq_nx     = 1'b1;
                    vector_nx  = win_vec;
                    req_idx_nx = win_idx;
                end
`endif
            end

            default: begin
                state_nx = ST_IDLE;
                irq_nx   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            req_idx    <= '0;
            irq        <= 1'b0;
            vector     <= '0;
            flag_clr   <= '0;
            in_service <= '0;
            proto_err  <= 1'b0;
        end else begin
            state      <= state_nx;
            req_idx    <= req_idx_nx;
            irq        <= irq_nx;
            vector     <= vector_nx;
            flag_clr   <= flag_clr_nx;
            in_service <= in_service_nx;
            proto_err  <= proto_err_nx;
        end
    end

endmodule

// File: tb/tb_irq_controller_n.sv
// Directed bench for irq_controller_n with NUM_SRC=4, VECTOR_BASE=2, VECTOR_STRIDE=2.
// Source i maps to vector 2+2*i; the IRQ_NESTING_EN build exercises preemption.
module tb_irq_controller_n;

    logic       clk;
    logic       reset;
    logic       gie;
    logic [3:0] src_flag;
    logic [3:0] src_mask;
    logic       irq_ack;
    logic       reti;
    logic       irq;
    logic [9:0] vector;
    logic [3:0] flag_clr;
    logic [3:0] in_service;
    logic       proto_err;

    int errors = 0;
    int checks = 0;

    irq_controller_n #(
        .NUM_SRC      (4),
        .I_ADDR_WIDTH (10),
        .VECTOR_BASE  (2),
        .VECTOR_STRIDE(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .gie       (gie),
        .src_flag  (src_flag),
        .src_mask  (src_mask),
        .irq_ack   (irq_ack),
        .reti      (reti),
        .irq       (irq),
        .vector    (vector),
        .flag_clr  (flag_clr),
        .in_service(in_service),
        .proto_err (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        gie      = 1'b0;
        src_flag = 4'b0000;
        src_mask = 4'b0000;
        irq_ack  = 1'b0;
        reti     = 1'b0;
        tick;
        tick;
        check("rst_irq",  32'(irq), 32'd0);
        check("rst_vec",  32'(vector), 32'd0);
        check("rst_fc",   32'(flag_clr), 32'd0);
        check("rst_isv",  32'(in_service), 32'd0);
        check("rst_perr", 32'(proto_err), 32'd0);
        reset = 1'b0;

        // Single source 2 request and service
        gie = 1'b1; src_mask = 4'hF; src_flag = 4'b0100;
        tick;
        check("A_irq", 32'(irq), 32'd1);
        check("A_vec", 32'(vector), 32'd6);
        check("A_fc",  32'(flag_clr), 32'd0);
        irq_ack = 1'b1;
        tick;
        check("A_ack_fc",  32'(flag_clr), 32'b0100);
        check("A_ack_isv", 32'(in_service), 32'b0100);
        check("A_ack_irq", 32'(irq), 32'd0);
        check("A_ack_vec", 32'(vector), 32'd6);
        irq_ack = 1'b0; src_flag = 4'b0000;
        tick;
        check("A_fc_once", 32'(flag_clr), 32'd0);
        check("A_isv",     32'(in_service), 32'b0100);
        reti = 1'b1;
        tick;
        check("A_reti_isv",  32'(in_service), 32'd0);
        check("A_reti_perr", 32'(proto_err), 32'd0);
        reti = 1'b0;

        // Sources 1 and 3 together: 1 wins, 3 waits for reti and IDLE
        src_flag = 4'b1010;
        tick;
        check("B_irq", 32'(irq), 32'd1);
        check("B_vec", 32'(vector), 32'd4);
        irq_ack = 1'b1;
        tick;
        check("B_fc",  32'(flag_clr), 32'b0010);
        check("B_isv", 32'(in_service), 32'b0010);
        irq_ack = 1'b0; src_flag = 4'b1000;
        tick;
        check("B_hold_irq", 32'(irq), 32'd0);
        tick;
        check("B_hold_irq2", 32'(irq), 32'd0);
        reti = 1'b1;
        tick;
        check("B_reti_isv", 32'(in_service), 32'd0);
        check("B_idle_irq", 32'(irq), 32'd0);
        reti = 1'b0;
        tick;
        check("B_src3_irq", 32'(irq), 32'd1);
        check("B_src3_vec", 32'(vector), 32'd8);
        irq_ack = 1'b1;
        tick;
        check("B3_fc",  32'(flag_clr), 32'b1000);
        check("B3_isv", 32'(in_service), 32'b1000);
        irq_ack = 1'b0; src_flag = 4'b0000; reti = 1'b1;
        tick;
        check("B3_reti_isv", 32'(in_service), 32'd0);
        reti = 1'b0;

        // gie drops while requesting
        src_flag = 4'b1010;
        tick;
        check("C_irq", 32'(irq), 32'd1);
        check("C_vec", 32'(vector), 32'd4);
        gie = 1'b0;
        tick;
        check("C_drop_irq", 32'(irq), 32'd0);
        check("C_drop_vec", 32'(vector), 32'd4);
        check("C_drop_fc",  32'(flag_clr), 32'd0);
        tick;
        check("C_idle_irq", 32'(irq), 32'd0);
        check("C_idle_fc",  32'(flag_clr), 32'd0);
        check("C_idle_isv", 32'(in_service), 32'd0);
        src_flag = 4'b0000; gie = 1'b1;

        // Ack without a request
        irq_ack = 1'b1;
        tick;
        check("D_perr", 32'(proto_err), 32'd1);
        check("D_fc",   32'(flag_clr), 32'd0);
        check("D_irq",  32'(irq), 32'd0);
        irq_ack = 1'b0;
        tick;
        check("D_perr_end", 32'(proto_err), 32'd0);

        // Reti with nothing in service
        reti = 1'b1;
        tick;
        check("E_perr", 32'(proto_err), 32'd1);
        check("E_isv",  32'(in_service), 32'd0);
        reti = 1'b0;
        tick;
        check("E_perr_end", 32'(proto_err), 32'd0);

        // Ack and reti together: ack taken, reti dropped
        src_flag = 4'b0001;
        tick;
        check("F_irq", 32'(irq), 32'd1);
        check("F_vec", 32'(vector), 32'd2);
        irq_ack = 1'b1; reti = 1'b1;
        tick;
        check("F_perr", 32'(proto_err), 32'd1);
        check("F_fc",   32'(flag_clr), 32'b0001);
        check("F_isv",  32'(in_service), 32'b0001);
        irq_ack = 1'b0; reti = 1'b0; src_flag = 4'b0000;
        tick;
        check("F_perr_end", 32'(proto_err), 32'd0);
        check("F_isv_kept", 32'(in_service), 32'b0001);
        reti = 1'b1;
        tick;
        check("F_isv_clr", 32'(in_service), 32'd0);
        check("F_reti_ok", 32'(proto_err), 32'd0);
        reti = 1'b0;

        // Vector tracks the current winner while requesting
        src_flag = 4'b1000;
        tick;
        check("G_vec8", 32'(vector), 32'd8);
        src_flag = 4'b1010;
        tick;
        check("G_vec4", 32'(vector), 32'd4);
        check("G_irq",  32'(irq), 32'd1);
        irq_ack = 1'b1;
        tick;
        check("G_fc",  32'(flag_clr), 32'b0010);
        check("G_isv", 32'(in_service), 32'b0010);
        irq_ack = 1'b0; src_flag = 4'b0000; reti = 1'b1;
        tick;
        check("G_reti_isv", 32'(in_service), 32'd0);
        reti = 1'b0;

        // Source 0 rises while source 2 is in service
        src_flag = 4'b0100;
        tick;
        check("H_irq", 32'(irq), 32'd1);
        check("H_vec", 32'(vector), 32'd6);
        irq_ack = 1'b1;
        tick;
        check("H_isv", 32'(in_service), 32'b0100);
        irq_ack = 1'b0; src_flag = 4'b0001;
        tick;
`ifdef IRQ_NESTING_EN
        check("H_pre_irq", 32'(irq), 32'd1);
        check("H_pre_vec", 32'(vector), 32'd2);
        irq_ack = 1'b1;
        tick;
        check("H_pre_fc",  32'(flag_clr), 32'b0001);
        check("H_pre_isv", 32'(in_service), 32'b0101);
        irq_ack = 1'b0; src_flag = 4'b0000; reti = 1'b1;
        tick;
        check("H_reti1_isv", 32'(in_service), 32'b0100);
        tick;
        check("H_reti2_isv", 32'(in_service), 32'd0);
        reti = 1'b0;
        tick;
        check("H_idle_irq", 32'(irq), 32'd0);
        src_flag = 4'b0010;
        tick;
        check("H_idle_req", 32'(irq), 32'd1);
        check("H_idle_vec", 32'(vector), 32'd4);
`else
        check("H_nopre_irq", 32'(irq), 32'd0);
        tick;
        check("H_nopre_irq2", 32'(irq), 32'd0);
        check("H_nopre_isv",  32'(in_service), 32'b0100);
        reti = 1'b1;
        tick;
        check("H_reti_isv", 32'(in_service), 32'd0);
        check("H_reti_irq", 32'(irq), 32'd0);
        reti = 1'b0;
        tick;
        check("H_src0_irq", 32'(irq), 32'd1);
        check("H_src0_vec", 32'(vector), 32'd2);
`endif

        // Reset on the ack edge: no flag_clr pulse
        irq_ack = 1'b1; reset = 1'b1;
        tick;
        check("I_fc",  32'(flag_clr), 32'd0);
        check("I_isv", 32'(in_service), 32'd0);
        check("I_irq", 32'(irq), 32'd0);
        check("I_vec", 32'(vector), 32'd0);
        irq_ack = 1'b0; reset = 1'b0; src_flag = 4'b0000;
        tick;

        // Reset mid-SERVICE
        src_flag = 4'b0100;
        tick;
        check("J_irq", 32'(irq), 32'd1);
        irq_ack = 1'b1;
        tick;
        check("J_isv", 32'(in_service), 32'b0100);
        irq_ack = 1'b0; src_flag = 4'b0000; reset = 1'b1;
        tick;
        check("J_rst_irq",  32'(irq), 32'd0);
        check("J_rst_vec",  32'(vector), 32'd0);
        check("J_rst_isv",  32'(in_service), 32'd0);
        check("J_rst_fc",   32'(flag_clr), 32'd0);
        check("J_rst_perr", 32'(proto_err), 32'd0);
        reset = 1'b0;
        tick;
        check("J_post_irq", 32'(irq), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/irq_controller_n.md
IRQ_CONTROLLER_N -- requirements
Module: irq_controller_n

Interface
REQ-001 SHALL have parameter NUM_SRC, default 3: number of interrupt sources, legal range 1..16; index 0 is the highest priority.
REQ-002 SHALL have parameter I_ADDR_WIDTH, default 10: vector width in bits.
REQ-003 SHALL have parameter VECTOR_BASE, default 1: vector of source 0.
REQ-004 SHALL have parameter VECTOR_STRIDE, default 1: vector distance between consecutive sources.
REQ-005 SHALL have port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port gie, input, 1 bit: global interrupt enable (SREG I bit).
REQ-008 SHALL have port src_flag, input, NUM_SRC bits: per-source pending flags.
REQ-009 SHALL have port src_mask, input, NUM_SRC bits: per-source enables.
REQ-010 SHALL have port irq_ack, input, 1 bit: CPU accepts the presented vector.
REQ-011 SHALL have port reti, input, 1 bit: CPU executed return-from-interrupt.
REQ-012 SHALL have port irq, output, 1 bit: interrupt request.
REQ-013 SHALL have port vector, output, I_ADDR_WIDTH bits: ISR address.
REQ-014 SHALL have port flag_clr, output, NUM_SRC bits: one-hot, one-cycle flag-clear pulse.
REQ-015 SHALL have port in_service, output, NUM_SRC bits: sources currently being serviced.
REQ-016 SHALL have port proto_err, output, 1 bit: one-cycle pulse on a handshake violation.

Function
REQ-017 Source i is eligible when gie & src_flag[i] & src_mask[i]; the winner SHALL be the lowest eligible index.
REQ-018 vector SHALL equal (VECTOR_BASE + idx*VECTOR_STRIDE) mod 2^I_ADDR_WIDTH.
REQ-019 The FSM SHALL have three states: IDLE, REQ, SERVICE; all outputs SHALL be registered.
REQ-020 In IDLE, if any source is eligible at edge N, the block SHALL enter REQ and drive irq=1 and the winner's vector after edge N (1-cycle latency).
REQ-021 In REQ, the winner SHALL be re-evaluated every cycle, and vector SHALL track the current winner until acknowledged.
REQ-022 In REQ, if no source is eligible (gie dropped or flag cleared), irq SHALL fall next cycle, vector SHALL hold its last value, and the FSM SHALL return to IDLE, or to SERVICE if in_service is nonzero.
REQ-023 On irq_ack=1 in REQ, the next cycle SHALL:
- pulse flag_clr for the acknowledged index for exactly one cycle;
- set that bit in in_service;
- set irq=0 and enter SERVICE;
- hold vector.
REQ-024 irq_ack while irq=0 SHALL be ignored and SHALL pulse proto_err.
REQ-025 reti SHALL clear the lowest-index set bit of in_service; when in_service becomes zero, the FSM SHALL enter IDLE.
REQ-026 reti with in_service=0 SHALL pulse proto_err and change no other state.
REQ-027 If irq_ack and reti are asserted in the same cycle, the ack SHALL be processed, the reti dropped, and proto_err pulsed.
REQ-028 In SERVICE, without nesting, no new request SHALL be raised; eligibility SHALL be evaluated only after the return to IDLE, so a pending source is requested 1 cycle after IDLE is entered.

Reset
REQ-029 On reset, the block SHALL force: irq=0, vector=0, flag_clr=0, in_service=0, proto_err=0, state=IDLE.
REQ-030 Reset SHALL override an in-progress REQ or SERVICE in the same edge; no flag_clr pulse is emitted.

Configuration
REQ-031 The macro IRQ_NESTING_EN SHALL control nesting.
- Defined: in SERVICE, a source with index lower than the lowest set in_service bit and eligible SHALL move the FSM to REQ (preemption); in_service may hold multiple bits.
- Undefined: in_service holds at most one bit and REQ-028 applies.

Verification
REQ-032 NUM_SRC=4, BASE=2, STRIDE=2: gie=1, mask=4'hF, flag=4'b0100 -> irq=1, vector=6 one cycle later; ack -> flag_clr=4'b0100, in_service=4'b0100.
REQ-033 flag=4'b1010 simultaneous -> vector=4 (source 1); source 3 is served only after reti and a return to IDLE.
REQ-034 In REQ, gie drops before ack -> irq=0 next cycle, vector holds 4, FSM returns to IDLE, flag_clr stays 0.
REQ-035 Nesting enabled, source 2 in service, flag[0] rises -> irq=1, vector=2; ack -> in_service=4'b0101; two retis -> 4'b0100 then 0, FSM in IDLE.
REQ-036 reti with in_service=0, and irq_ack with reti in the same cycle -> proto_err pulses one cycle each; reset asserted mid-SERVICE -> all outputs return to 0.
